asm_regfile_mc: RTL and testbench
=================================

Name: asm_regfile_mc

Overview:
- Parametrised multi-core successor of the accelerator-domain PicoRV control register file: one register bank per core behind a single TCU register interface.
- Each bank adds to the single-core register set: sticky trap capture, saturating trap counter, set-by-write/clear-by-EOI interrupt pending bits, and a sticky EOI log.
- Sits between the TCU config port and NUM_CORES PicoRV cores and accelerators.

Parameters:
- NUM_CORES, 4, number of core banks (1..16).
- BANK_SHIFT, 6, log2 of byte stride between banks (0x40).
- PICO_STACKADDR, 'h40000, reset value of every core's stack address.
- TRAPCNT_WIDTH, 16, width of the per-core saturating trap counter.
- TCU_REG_ADDR_SIZE / TCU_REG_DATA_SIZE / TCU_REG_BSEL_SIZE, 32 / 64 / 8, taken from the codebase TCU parameter include.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- config_en_i  in  1  register access strobe.
- config_wben_i  in  TCU_REG_BSEL_SIZE  byte write enables; nonzero = write, zero = read.
- config_addr_i  in  TCU_REG_ADDR_SIZE  byte address.
- config_wdata_i  in  TCU_REG_DATA_SIZE  write data.
- config_rdata_o  out  TCU_REG_DATA_SIZE  read data, registered.
- asm_en_o  out  NUM_CORES  per-core ASM enable.
- acc_en_o  out  NUM_CORES  per-core accelerator enable.
- pico_trap_i  in  NUM_CORES  per-core trap level.
- pico_irq_o  out  32*NUM_CORES  pending IRQs, core c at [32c +: 32].
- pico_eoi_i  in  32*NUM_CORES  EOI pulses, same packing.
- pico_stackaddr_o  out  32*NUM_CORES  stack addresses.

Behaviour:
- Reset: clk_i and reset_i only; reset is synchronous and active-high.
- Reset values: asm_en_o=0, acc_en_o=0, pico_irq_o=0, config_rdata_o=0, pico_stackaddr_o = PICO_STACKADDR replicated; internal trap, EOI log, trap counters and input-sampling registers = 0.
- Address decode: core index = addr >> BANK_SHIFT; offset = addr[BANK_SHIFT-1:0].
  - Index >= NUM_CORES: writes ignored, reads return 0.
  - Upper unused address bits must be 0, otherwise the access is treated as unmapped.
- Bank offsets:
  - 0x00 ASM_EN: RW, bit0.
  - 0x08 ACC_EN: RW, bit0.
  - 0x10 TRAP: bit0 sticky; write 1 with wben[0] clears it.
  - 0x18 IRQ: read = pending[31:0]; write ORs wdata bytes into pending, per wben[3:0].
  - 0x20 EOI_LOG: sticky OR of received EOIs; write-1-to-clear per byte.
  - 0x28 STACKADDR: RW, 32 bits, byte enables wben[3:0].
  - 0x30 TRAPCNT: read-only, zero-extended.
  - Other offsets: reads return 0, writes ignored.
- Read latency: exactly 1 cycle; config_rdata_o holds its last value until the next read.
- Writes: take effect on the next clock edge; outputs reflect them 1 cycle after the write strobe.
- Trap:
  - pico_trap_i is registered once (r_trap_d).
  - A rising edge (sample=1, previous=0) sets TRAP and increments TRAPCNT.
  - TRAPCNT saturates at all-ones and does not wrap.
  - Trap set and W1C in the same cycle: set wins.
- IRQ pending:
  - An EOI bit clears the corresponding pending bit and sets the EOI_LOG bit in the same cycle.
  - IRQ write-set and EOI on the same bit in the same cycle: set wins (pending stays 1); EOI_LOG is still set.
  - EOI_LOG set and W1C in the same cycle: set wins.
- Reads of TRAP / IRQ / EOI_LOG return the pre-update register value of the current cycle.
- Reset asserted mid-operation: all state returns to reset values on the next edge; an in-flight read returns 0.

Optional Feature:
- Macro: ASM_REGFILE_TRAP_HALT_EN.
- Defined: a trap rising edge also clears that core's asm_en on the same edge that sets TRAP. A software write of 1 to ASM_EN in the same cycle loses to the halt.
- Undefined: traps never affect asm_en.

Test Plan:
- Reset, then read core2 STACKADDR (addr 0xA8) -> rdata 0x40000 one cycle later; all enables 0, all pico_irq_o 0.
- Write 0x1 to 0x40 (core1 ASM_EN), wben=0x01 -> asm_en_o=4'b0010 next cycle; same write to addr 0x100 (core4, NUM_CORES=4) -> no change; read of 0x100 -> 0.
- Write 0x80000001 to core0 IRQ, wben=0x0F -> pico_irq_o[31:0]=0x80000001; pulse pico_eoi_i[0] -> pending 0x80000000, EOI_LOG=0x1.
- Same-cycle IRQ write-set bit5 and pico_eoi_i[5] on core3 -> pending bit5=1, EOI_LOG bit5=1.
- Hold pico_trap_i[1] high 10 cycles, then three more 0->1 pulses -> TRAP=1, TRAPCNT=4; W1C TRAP -> 0. Force TRAPCNT to saturate at 0xFFFF: it stays at 0xFFFF.
- With ASM_REGFILE_TRAP_HALT_EN defined: asm_en[0]=1, trap edge on core0 coincident with an ASM_EN write of 1 -> asm_en[0]=0. Without the macro -> asm_en[0]=1.

Source files
------------

// File: rtl/asm_regfile_mc.sv
// asm_regfile_mc: per-core PicoRV control/status register banks behind one TCU config port.
// Optional build macro ASM_REGFILE_TRAP_HALT_EN: a trap rising edge also clears that core's ASM enable.
module asm_regfile_mc #(
    parameter int          NUM_CORES         = 4,
    parameter int          BANK_SHIFT        = 6,
    parameter logic [31:0] PICO_STACKADDR    = 32'h0004_0000,
    parameter int          TRAPCNT_WIDTH     = 16,
    parameter int          TCU_REG_ADDR_SIZE = 32,
    parameter int          TCU_REG_DATA_SIZE = 64,
    parameter int          TCU_REG_BSEL_SIZE = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         config_en_i,
    input  logic [TCU_REG_BSEL_SIZE-1:0] config_wben_i,
    input  logic [TCU_REG_ADDR_SIZE-1:0] config_addr_i,
    input  logic [TCU_REG_DATA_SIZE-1:0] config_wdata_i,
    output logic [TCU_REG_DATA_SIZE-1:0] config_rdata_o,
    output logic [NUM_CORES-1:0]         asm_en_o,
    output logic [NUM_CORES-1:0]         acc_en_o,
    input  logic [NUM_CORES-1:0]         pico_trap_i,
    output logic [32*NUM_CORES-1:0]      pico_irq_o,
    input  logic [32*NUM_CORES-1:0]      pico_eoi_i,
    output logic [32*NUM_CORES-1:0]      pico_stackaddr_o
);

    localparam int CIDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [BANK_SHIFT-1:0] OFF_ASM_EN    = BANK_SHIFT'(6'h00);
    localparam logic [BANK_SHIFT-1:0] OFF_ACC_EN    = BANK_SHIFT'(6'h08);
    localparam logic [BANK_SHIFT-1:0] OFF_TRAP      = BANK_SHIFT'(6'h10);
    localparam logic [BANK_SHIFT-1:0] OFF_IRQ       = BANK_SHIFT'(6'h18);
    localparam logic [BANK_SHIFT-1:0] OFF_EOI_LOG   = BANK_SHIFT'(6'h20);
    localparam logic [BANK_SHIFT-1:0] OFF_STACKADDR = BANK_SHIFT'(6'h28);
    localparam logic [BANK_SHIFT-1:0] OFF_TRAPCNT   = BANK_SHIFT'(6'h30);

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [TRAPCNT_WIDTH-1:0] sat_inc(input logic [TRAPCNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + TRAPCNT_WIDTH'(1);
    endfunction

    // Expand the low four byte enables into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    logic [TCU_REG_ADDR_SIZE-1:0] w_bank;
    logic [CIDX_W-1:0]            w_bank_idx;
    logic [BANK_SHIFT-1:0]        w_off;
    logic                         w_mapped;
    logic                         w_wr;
    logic                         w_rd_req;
    logic [31:0]                  w_wdata32;
    logic [31:0]                  w_bmask;
    logic                         w_unused_wdata;

    // Any nonzero bit above the bank index field lands outside the core range and is unmapped.
    assign w_bank         = config_addr_i >> BANK_SHIFT;
    assign w_bank_idx     = w_bank[CIDX_W-1:0];
    assign w_off          = config_addr_i[BANK_SHIFT-1:0];
    assign w_mapped       = (w_bank < TCU_REG_ADDR_SIZE'(NUM_CORES));
    assign w_wr           = config_en_i && (config_wben_i != '0) && w_mapped;
    assign w_rd_req       = config_en_i && (config_wben_i == '0);
    assign w_wdata32      = config_wdata_i[31:0];
    assign w_bmask        = byte_mask(config_wben_i[3:0]);
    assign w_unused_wdata = ^config_wdata_i[TCU_REG_DATA_SIZE-1:32];

    logic [TCU_REG_DATA_SIZE-1:0] w_rd_val [NUM_CORES];
    logic [TCU_REG_DATA_SIZE-1:0] r_rdata;

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
        logic                     w_sel;
        logic                     w_trap_rise;
        logic                     w_trap_clr;
        logic                     w_asm_nxt;
        logic [31:0]              w_eoi;
        logic [31:0]              w_irq_set;
        logic [31:0]              w_log_clr;
        logic [31:0]              w_stk_mask;
        logic [TCU_REG_DATA_SIZE-1:0] w_rd;

        logic                     r_asm_en;
        logic                     r_acc_en;
        logic                     r_trap_d;
        logic                     r_trap;
        logic [TRAPCNT_WIDTH-1:0] r_trapcnt;
        logic [31:0]              r_pending;
        logic [31:0]              r_eoi_log;
        logic [31:0]              r_stackaddr;

        assign w_sel       = w_wr && (w_bank_idx == CIDX_W'(c));
        assign w_eoi       = pico_eoi_i[32*c +: 32];
        assign w_trap_rise = pico_trap_i[c] & ~r_trap_d;
        assign w_trap_clr  = w_sel && (w_off == OFF_TRAP) && config_wben_i[0] && w_wdata32[0];
        assign w_irq_set   = (w_sel && (w_off == OFF_IRQ))       ? (w_wdata32 & w_bmask) : 32'd0;
        assign w_log_clr   = (w_sel && (w_off == OFF_EOI_LOG))   ? (w_wdata32 & w_bmask) : 32'd0;
        assign w_stk_mask  = (w_sel && (w_off == OFF_STACKADDR)) ? w_bmask : 32'd0;

        always_comb begin
            w_asm_nxt = r_asm_en;
            if (w_sel && (w_off == OFF_ASM_EN) && config_wben_i[0]) begin
                w_asm_nxt = w_wdata32[0];
            end
`ifdef ASM_REGFILE_TRAP_HALT_EN
            // Halt beats a same-cycle software enable.
            if (w_trap_rise) begin
                w_asm_nxt = 1'b0;
            end
`endif
        end

        // Hardware set terms are OR-ed in last so they win over same-cycle clears.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_asm_en    <= 1'b0;
                r_acc_en    <= 1'b0;
                r_trap_d    <= 1'b0;
                r_trap      <= 1'b0;
                r_trapcnt   <= '0;
                r_pending   <= 32'd0;
                r_eoi_log   <= 32'd0;
                r_stackaddr <= PICO_STACKADDR;
            end else begin
                r_asm_en <= w_asm_nxt;
                if (w_sel && (w_off == OFF_ACC_EN) && config_wben_i[0]) begin
                    r_acc_en <= w_wdata32[0];
                end
                r_trap_d <= pico_trap_i[c];
                r_trap   <= w_trap_rise | (r_trap & ~w_trap_clr);
                if (w_trap_rise) begin
                    r_trapcnt <= sat_inc(r_trapcnt);
                end
                r_pending   <= (r_pending & ~w_eoi) | w_irq_set;
                r_eoi_log   <= (r_eoi_log & ~w_log_clr) | w_eoi;
                r_stackaddr <= (r_stackaddr & ~w_stk_mask) | (w_wdata32 & w_stk_mask);
            end
        end

        always_comb begin
            w_rd = '0;
            case (w_off)
                OFF_ASM_EN:    w_rd[0]                 = r_asm_en;
                OFF_ACC_EN:    w_rd[0]                 = r_acc_en;
                OFF_TRAP:      w_rd[0]                 = r_trap;
                OFF_IRQ:       w_rd[31:0]              = r_pending;
                OFF_EOI_LOG:   w_rd[31:0]              = r_eoi_log;
                OFF_STACKADDR: w_rd[31:0]              = r_stackaddr;
                OFF_TRAPCNT:   w_rd[TRAPCNT_WIDTH-1:0] = r_trapcnt;
                default:       w_rd                    = '0;
            endcase
        end

        assign w_rd_val[c]                 = w_rd;
        assign asm_en_o[c]                 = r_asm_en;
        assign acc_en_o[c]                 = r_acc_en;
        assign pico_irq_o[32*c +: 32]      = r_pending;
        assign pico_stackaddr_o[32*c +: 32] = r_stackaddr;
    end

    // Read data is captured from pre-update state and held until the next read.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rdata <= '0;
        end else if (w_rd_req) begin
            r_rdata <= w_mapped ? w_rd_val[w_bank_idx] : '0;
        end
    end

    assign config_rdata_o = r_rdata;

endmodule

// File: tb/tb_asm_regfile_mc.sv
// Self-checking bench for asm_regfile_mc: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_asm_regfile_mc;

    localparam int NC     = 4;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic            clk;
    logic            rst;
    logic            en;
    logic [7:0]      wben;
    logic [31:0]     addr;
    logic [63:0]     wdata;
    logic [63:0]     rdata;
    logic [NC-1:0]   asm_en;
    logic [NC-1:0]   acc_en;
    logic [NC-1:0]   trap;
    logic [32*NC-1:0] irq;
    logic [32*NC-1:0] eoi;
    logic [32*NC-1:0] stk;

    asm_regfile_mc #(
        .NUM_CORES     (NC),
        .TRAPCNT_WIDTH (CW)
    ) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .config_en_i      (en),
        .config_wben_i    (wben),
        .config_addr_i    (addr),
        .config_wdata_i   (wdata),
        .config_rdata_o   (rdata),
        .asm_en_o         (asm_en),
        .acc_en_o         (acc_en),
        .pico_trap_i      (trap),
        .pico_irq_o       (irq),
        .pico_eoi_i       (eoi),
        .pico_stackaddr_o (stk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic        m_asm    [NC];
    logic        m_acc    [NC];
    logic        m_trap   [NC];
    logic        m_trap_d [NC];
    int          m_cnt    [NC];
    logic [31:0] m_pend   [NC];
    logic [31:0] m_log    [NC];
    logic [31:0] m_stk    [NC];
    logic [63:0] m_rdata;

    function automatic logic [31:0] bmask(input logic [7:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic logic [63:0] model_read(input int c, input logic [5:0] off);
        case (off)
            6'h00:   return {63'd0, m_asm[c]};
            6'h08:   return {63'd0, m_acc[c]};
            6'h10:   return {63'd0, m_trap[c]};
            6'h18:   return {32'd0, m_pend[c]};
            6'h20:   return {32'd0, m_log[c]};
            6'h28:   return {32'd0, m_stk[c]};
            6'h30:   return 64'(m_cnt[c]);
            default: return 64'd0;
        endcase
    endfunction

    // One clock of the register map: software effects first, hardware events after (they win).
    task automatic model_step();
        logic [31:0] bank;
        logic [5:0]  off;
        logic        mapped;
        logic        wr;
        logic        sel;
        logic        rise;
        logic [31:0] bm;
        logic [31:0] ev;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                m_asm[c] = 0; m_acc[c] = 0; m_trap[c] = 0; m_trap_d[c] = 0;
                m_cnt[c] = 0; m_pend[c] = 0; m_log[c] = 0; m_stk[c] = 32'h40000;
            end
            m_rdata = 64'd0;
        end else begin
            bank   = addr >> 6;
            off    = addr[5:0];
            mapped = (bank < NC);
            wr     = en && (wben != 8'd0) && mapped;
            bm     = bmask(wben);
            if (en && wben == 8'd0) m_rdata = mapped ? model_read(int'(bank), off) : 64'd0;
            for (int c = 0; c < NC; c++) begin
                sel  = wr && (bank == c);
                rise = trap[c] && !m_trap_d[c];
                ev   = eoi[32*c +: 32];
                m_trap_d[c] = trap[c];
                if (sel && off == 6'h00 && wben[0]) m_asm[c] = wdata[0];
                if (sel && off == 6'h08 && wben[0]) m_acc[c] = wdata[0];
                if (sel && off == 6'h10 && wben[0] && wdata[0]) m_trap[c] = 0;
                if (sel && off == 6'h20) m_log[c] = m_log[c] & ~(wdata[31:0] & bm);
                if (sel && off == 6'h28) m_stk[c] = (m_stk[c] & ~bm) | (wdata[31:0] & bm);
                m_pend[c] = m_pend[c] & ~ev;
                if (sel && off == 6'h18) m_pend[c] = m_pend[c] | (wdata[31:0] & bm);
                m_log[c] = m_log[c] | ev;
                if (rise) begin
                    m_trap[c] = 1;
                    if (m_cnt[c] < CNTMAX) m_cnt[c] = m_cnt[c] + 1;
`ifdef ASM_REGFILE_TRAP_HALT_EN
                    m_asm[c] = 0;
`endif
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; wben = 8'd0; wdata = 64'd0; eoi = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] be, input logic [63:0] d);
        en = 1; wben = be; addr = a; wdata = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [31:0] a);
        en = 1; wben = 8'd0; addr = a;
        tick();
        idle();
    endtask

    function automatic logic [NC-1:0] exp_asm();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = m_asm[c];
        return v;
    endfunction

    function automatic logic [NC-1:0] exp_acc();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = m_acc[c];
        return v;
    endfunction

    function automatic logic [32*NC-1:0] exp_irq();
        logic [32*NC-1:0] v;
        for (int c = 0; c < NC; c++) v[32*c +: 32] = m_pend[c];
        return v;
    endfunction

    function automatic logic [32*NC-1:0] exp_stk();
        logic [32*NC-1:0] v;
        for (int c = 0; c < NC; c++) v[32*c +: 32] = m_stk[c];
        return v;
    endfunction

    task automatic test_reset();
        rst = 1; idle(); trap = '0; addr = 32'd0;
        tick(); tick();
        rst = 0;
        n_cmp++; if (asm_en !== 4'b0000) begin n_fail++; $display("FAIL reset_asm_en got %b exp 0000", asm_en); end
        n_cmp++; if (acc_en !== 4'b0000) begin n_fail++; $display("FAIL reset_acc_en got %b exp 0000", acc_en); end
        n_cmp++; if (irq !== '0) begin n_fail++; $display("FAIL reset_irq got %h exp 0", irq); end
        n_cmp++; if (rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        n_cmp++; if (stk !== {NC{32'h0004_0000}}) begin n_fail++; $display("FAIL reset_stack got %h", stk); end
        rd(32'hA8);
        n_cmp++; if (rdata !== 64'h40000) begin n_fail++; $display("FAIL rd_core2_stack got %h exp 40000", rdata); end
    endtask

    task automatic test_decode();
        wr(32'h40, 8'h01, 64'h1);
        n_cmp++; if (asm_en !== 4'b0010) begin n_fail++; $display("FAIL wr_core1_asm got %b exp 0010", asm_en); end
        wr(32'h100, 8'h01, 64'h1);
        n_cmp++; if (asm_en !== 4'b0010) begin n_fail++; $display("FAIL wr_core4_ignored got %b exp 0010", asm_en); end
        rd(32'h100);
        n_cmp++; if (rdata !== 64'd0) begin n_fail++; $display("FAIL rd_core4_zero got %h exp 0", rdata); end
        wr(32'h0010_0048, 8'h01, 64'h1);
        n_cmp++; if (acc_en !== 4'b0000) begin n_fail++; $display("FAIL upper_addr_ignored got %b exp 0000", acc_en); end
        rd(32'h40);
        rd(32'h78);
        n_cmp++; if (rdata !== 64'd0) begin n_fail++; $display("FAIL rd_bad_offset got %h exp 0", rdata); end
        wr(32'h68, 8'h06, 64'hFFFF_FFFF_DEAD_BEEF);
        n_cmp++; if (stk[63:32] !== 32'h00AD_BE00) begin n_fail++; $display("FAIL stack_bytes got %h exp 00adbe00", stk[63:32]); end
    endtask

    task automatic test_irq();
        wr(32'h18, 8'h0F, 64'h8000_0001);
        n_cmp++; if (irq[31:0] !== 32'h8000_0001) begin n_fail++; $display("FAIL irq_set got %h exp 80000001", irq[31:0]); end
        eoi[0] = 1'b1;
        tick();
        idle();
        n_cmp++; if (irq[31:0] !== 32'h8000_0000) begin n_fail++; $display("FAIL irq_eoi got %h exp 80000000", irq[31:0]); end
        rd(32'h20);
        n_cmp++; if (rdata !== 64'h1) begin n_fail++; $display("FAIL eoi_log got %h exp 1", rdata); end
        wr(32'h18, 8'h02, 64'hFFFF_FFFF);
        n_cmp++; if (irq[31:0] !== 32'h8000_FF00) begin n_fail++; $display("FAIL irq_byte_set got %h exp 8000ff00", irq[31:0]); end
    endtask

    task automatic test_irq_eoi_same();
        en = 1; wben = 8'h0F; addr = 32'hD8; wdata = 64'h20; eoi[96+5] = 1'b1;
        tick();
        idle();
        n_cmp++; if (irq[96+5] !== 1'b1) begin n_fail++; $display("FAIL irq_set_vs_eoi got %b exp 1", irq[96+5]); end
        rd(32'hE0);
        n_cmp++; if (rdata !== 64'h20) begin n_fail++; $display("FAIL eoi_log_core3 got %h exp 20", rdata); end
        en = 1; wben = 8'h01; addr = 32'hE0; wdata = 64'h20; eoi[96+5] = 1'b1;
        tick();
        idle();
        rd(32'hE0);
        n_cmp++; if (rdata !== 64'h20) begin n_fail++; $display("FAIL log_set_vs_w1c got %h exp 20", rdata); end
        wr(32'hE0, 8'h01, 64'h20);
        rd(32'hE0);
        n_cmp++; if (rdata !== 64'h0) begin n_fail++; $display("FAIL log_w1c got %h exp 0", rdata); end
    endtask

    task automatic test_trap();
        trap[1] = 1'b1;
        repeat (10) tick();
        trap[1] = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            trap[1] = 1'b1; tick();
            trap[1] = 1'b0; tick();
        end
        rd(32'h50);
        n_cmp++; if (rdata !== 64'h1) begin n_fail++; $display("FAIL trap_sticky got %h exp 1", rdata); end
        rd(32'h70);
        n_cmp++; if (rdata !== 64'h4) begin n_fail++; $display("FAIL trapcnt_4 got %h exp 4", rdata); end
        wr(32'h50, 8'h01, 64'h1);
        rd(32'h50);
        n_cmp++; if (rdata !== 64'h0) begin n_fail++; $display("FAIL trap_w1c got %h exp 0", rdata); end
        en = 1; wben = 8'h01; addr = 32'h50; wdata = 64'h1; trap[1] = 1'b1;
        tick();
        idle();
        trap[1] = 1'b0;
        tick();
        rd(32'h50);
        n_cmp++; if (rdata !== 64'h1) begin n_fail++; $display("FAIL trap_set_vs_w1c got %h exp 1", rdata); end
        for (int i = 0; i < 20; i++) begin
            trap[1] = 1'b1; tick();
            trap[1] = 1'b0; tick();
        end
        rd(32'h70);
        n_cmp++; if (rdata !== 64'(CNTMAX)) begin n_fail++; $display("FAIL trapcnt_sat got %h exp %h", rdata, CNTMAX); end
        trap[1] = 1'b1; tick();
        trap[1] = 1'b0; tick();
        rd(32'h70);
        n_cmp++; if (rdata !== 64'(CNTMAX)) begin n_fail++; $display("FAIL trapcnt_no_wrap got %h exp %h", rdata, CNTMAX); end
    endtask

    task automatic test_halt();
        logic exp0;
`ifdef ASM_REGFILE_TRAP_HALT_EN
        exp0 = 1'b0;
`else
        exp0 = 1'b1;
`endif
        wr(32'h00, 8'h01, 64'h1);
        n_cmp++; if (asm_en[0] !== 1'b1) begin n_fail++; $display("FAIL asm0_on got %b exp 1", asm_en[0]); end
        en = 1; wben = 8'h01; addr = 32'h00; wdata = 64'h1; trap[0] = 1'b1;
        tick();
        idle();
        trap[0] = 1'b0;
        n_cmp++; if (asm_en[0] !== exp0) begin n_fail++; $display("FAIL trap_halt got %b exp %b", asm_en[0], exp0); end
        rd(32'h10);
        n_cmp++; if (rdata !== 64'h1) begin n_fail++; $display("FAIL trap0_set got %h exp 1", rdata); end
    endtask

    task automatic test_random();
        int k;
        logic [31:0] a;
        for (int n = 0; n < 600; n++) begin
            en = ($urandom_range(0, 9) < 7);
            wben = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            a = 32'($urandom_range(0, 5)) * 32'd64;
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(0, 63));
            else a = a + 32'($urandom_range(0, 7)) * 32'd8;
            if ($urandom_range(0, 19) == 0) a = a | (32'd1 << $urandom_range(12, 31));
            addr  = a;
            wdata = {$urandom, $urandom};
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 3) == 0) eoi[32*c +: 32] = $urandom & $urandom & $urandom;
                else eoi[32*c +: 32] = 32'd0;
            end
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, NC-1);
                trap[k] = ~trap[k];
            end
            tick();
            n_cmp++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", n, rdata, m_rdata); end
            n_cmp++; if (asm_en !== exp_asm()) begin n_fail++; $display("FAIL rnd_asm cyc %0d got %b exp %b", n, asm_en, exp_asm()); end
            n_cmp++; if (acc_en !== exp_acc()) begin n_fail++; $display("FAIL rnd_acc cyc %0d got %b exp %b", n, acc_en, exp_acc()); end
            n_cmp++; if (irq !== exp_irq()) begin n_fail++; $display("FAIL rnd_irq cyc %0d got %h exp %h", n, irq, exp_irq()); end
            n_cmp++; if (stk !== exp_stk()) begin n_fail++; $display("FAIL rnd_stack cyc %0d got %h exp %h", n, stk, exp_stk()); end
        end
        idle();
        trap = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        wr(32'h40, 8'h01, 64'h1);
        wr(32'h18, 8'h0F, 64'h55);
        rd(32'h68);
        en = 1; wben = 8'd0; addr = 32'hA8; rst = 1;
        tick();
        rst = 0;
        idle();
        n_cmp++; if (rdata !== 64'd0) begin n_fail++; $display("FAIL midreset_rdata got %h exp 0", rdata); end
        n_cmp++; if (asm_en !== 4'b0000) begin n_fail++; $display("FAIL midreset_asm got %b exp 0000", asm_en); end
        n_cmp++; if (irq !== '0) begin n_fail++; $display("FAIL midreset_irq got %h exp 0", irq); end
        rd(32'h70);
        n_cmp++; if (rdata !== 64'd0) begin n_fail++; $display("FAIL midreset_trapcnt got %h exp 0", rdata); end
    endtask

    initial begin
        rst = 1; en = 0; wben = 8'd0; addr = 32'd0; wdata = 64'd0; trap = '0; eoi = '0;
        test_reset();
        test_decode();
        test_irq();
        test_irq_eoi_same();
        test_trap();
        test_halt();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
